// File: rtl/pipe_hazard_tracker.sv
// -----------------------------------------------------------------------------
// pipe_hazard_tracker
//
// Decode-side hazard unit for a pipeline with DEPTH post-decode stages.
// A shift register of pending writes (one entry per stage: valid, id, is_load)
// follows each decoded instruction down the pipe. For every decode source
// operand the youngest matching entry decides whether the value can be
// forwarded (fwd_sel) or the decode instruction has to wait (load-use or
// not-yet-ready ALU result). It also produces the fetch/decode flush strobes.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   ext_stall       freezes the whole pipe (memory wait); entries hold
//   issue_*         the instruction currently in decode
//   src_used/src_id decode source operands, operand s at [s*REG_ID_W +: REG_ID_W]
//   redirect        taken branch/jump resolved in decode
//   stall           hold PC and F/D register
//   flush_fd        clear F/D register
//   flush_de        insert a bubble into D/E register
//   fwd_sel         per operand: 0 = register file, k = result of stage k-1
//   pending         number of valid write entries
//   stall_cycles    saturating count of hazard stall cycles
//
// Optional feature macro: HAZARD_PERF_EN builds the stall_cycles counter;
// without it stall_cycles is tied to zero.
// -----------------------------------------------------------------------------
module pipe_hazard_tracker #(
    parameter int REG_ID_W = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int ALU_RDY  = 1,
    parameter int LOAD_RDY = 2,
    localparam int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ext_stall,
    input  logic                        issue_valid,
    input  logic                        issue_wr_en,
    input  logic [REG_ID_W-1:0]         issue_wr_id,
    input  logic                        issue_is_load,
    input  logic [NUM_SRC-1:0]          src_used,
    input  logic [NUM_SRC*REG_ID_W-1:0] src_id,
    input  logic                        redirect,
    output logic                        stall,
    output logic                        flush_fd,
    output logic                        flush_de,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic [SEL_W-1:0]            pending,
    output logic [15:0]                 stall_cycles
);

    // Entry k lives at bit k (valid/load) or slice k (id); entry 0 is stage E.
    logic [DEPTH-1:0]          ent_v_r;
    logic [DEPTH*REG_ID_W-1:0] ent_id_r;
    logic [DEPTH-1:0]          ent_ld_r;

    logic                      haz_s;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel_s;
    logic [SEL_W-1:0]          pending_s;
    logic [SEL_W:0]            res_s [NUM_SRC];
    logic                      new_v_s;

    // Resolve one operand: returns {haz, sel}. The scan runs old-to-young so
    // the youngest (lowest k) matching entry is the one left standing.
    function automatic logic [SEL_W:0] resolve(
        input logic                        used,
        input logic [REG_ID_W-1:0]         id,
        input logic [DEPTH-1:0]            v,
        input logic [DEPTH*REG_ID_W-1:0]   ids,
        input logic [DEPTH-1:0]            ld
    );
        logic             hit;
        logic [SEL_W-1:0] k_hit;
        logic             ld_hit;
        logic [SEL_W-1:0] rdy;
        logic [SEL_W:0]   r;
        hit    = 1'b0;
        k_hit  = '0;
        ld_hit = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (used && (id != '0) && v[k] && (ids[k*REG_ID_W +: REG_ID_W] == id)) begin
                hit    = 1'b1;
                k_hit  = SEL_W'(k);
                ld_hit = ld[k];
            end else begin
                hit    = hit;
            end
        end
        rdy = ld_hit ? SEL_W'(LOAD_RDY) : SEL_W'(ALU_RDY);
        if (!hit) begin
            r = '0;
        end else if (k_hit >= rdy) begin
            r = {1'b0, k_hit + SEL_W'(1)};
        end else begin
            r = {1'b1, {SEL_W{1'b0}}};
        end
        return r;
    endfunction

    // Operand matching: forward selects and the combined hazard flag.
    always_comb begin
        haz_s     = 1'b0;
        fwd_sel_s = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            res_s[s] = resolve(src_used[s], src_id[s*REG_ID_W +: REG_ID_W],
                               ent_v_r, ent_id_r, ent_ld_r);
            haz_s = haz_s | res_s[s][SEL_W];
            fwd_sel_s[s*SEL_W +: SEL_W] = res_s[s][SEL_W-1:0];
        end
    end

    // Population count of valid entries.
    always_comb begin
        pending_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pending_s = pending_s + SEL_W'(ent_v_r[k]);
        end
    end

    // A stalled or empty decode slot enters the pipe as a bubble; id 0 is
    // never tracked because it always reads as zero.
    assign new_v_s = ~haz_s & issue_valid & issue_wr_en & (issue_wr_id != '0);

    // Scoreboard shift register; frozen entirely while ext_stall is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_v_r  <= '0;
            ent_id_r <= '0;
            ent_ld_r <= '0;
        end else if (!ext_stall) begin
            ent_v_r  <= {ent_v_r[DEPTH-2:0], new_v_s};
            ent_id_r <= {ent_id_r[(DEPTH-1)*REG_ID_W-1:0], issue_wr_id};
            ent_ld_r <= {ent_ld_r[DEPTH-2:0], issue_is_load};
        end
    end

    // A redirect under a hazard is held off; the branch re-resolves next cycle.
    assign stall    = haz_s | ext_stall;
    assign flush_de = haz_s & ~ext_stall;
    assign flush_fd = redirect & ~haz_s & ~ext_stall;
    assign fwd_sel  = fwd_sel_s;
    assign pending  = pending_s;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cycles_r;

    // Saturating count of cycles lost to data hazards (memory waits excluded).
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_r <= 16'h0000;
        end else if (haz_s && !ext_stall && (stall_cycles_r != 16'hFFFF)) begin
            stall_cycles_r <= stall_cycles_r + 16'h0001;
        end
    end

    assign stall_cycles = stall_cycles_r;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_tracker
//
// Directed bench for pipe_hazard_tracker with default parameters. Each cycle
// the stimulus process drives decode inputs and queues the hand-computed
// expected outputs; a monitor process samples the DUT on the falling edge,
// pops the queue and compares.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_tracker;

    logic        clk;
    logic        reset;
    logic        ext_stall;
    logic        issue_valid;
    logic        issue_wr_en;
    logic [4:0]  issue_wr_id;
    logic        issue_is_load;
    logic [1:0]  src_used;
    logic [9:0]  src_id;
    logic        redirect;
    logic        stall;
    logic        flush_fd;
    logic        flush_de;
    logic [3:0]  fwd_sel;
    logic [1:0]  pending;
    logic [15:0] stall_cycles;

    typedef struct {
        int          tag;
        logic        st;
        logic        ffd;
        logic        fde;
        logic [3:0]  fwd;
        logic [1:0]  pend;
        logic [15:0] sc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   tag    = 0;
    logic [15:0] exp_sc = 16'h0000;

    pipe_hazard_tracker dut (
        .clk           (clk),
        .reset         (reset),
        .ext_stall     (ext_stall),
        .issue_valid   (issue_valid),
        .issue_wr_en   (issue_wr_en),
        .issue_wr_id   (issue_wr_id),
        .issue_is_load (issue_is_load),
        .src_used      (src_used),
        .src_id        (src_id),
        .redirect      (redirect),
        .stall         (stall),
        .flush_fd      (flush_fd),
        .flush_de      (flush_de),
        .fwd_sel       (fwd_sel),
        .pending       (pending),
        .stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int t, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, t, act, req);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall",        e.tag, {15'd0, stall},    {15'd0, e.st});
                chk("flush_fd",     e.tag, {15'd0, flush_fd}, {15'd0, e.ffd});
                chk("flush_de",     e.tag, {15'd0, flush_de}, {15'd0, e.fde});
                chk("fwd_sel",      e.tag, {12'd0, fwd_sel},  {12'd0, e.fwd});
                chk("pending",      e.tag, {14'd0, pending},  {14'd0, e.pend});
                chk("stall_cycles", e.tag, stall_cycles,      e.sc);
            end
        end
    end

    // One decode cycle: drive inputs after the edge and queue the expectation.
    task automatic cyc(
        input logic rst, input logic es, input logic iv, input logic we,
        input logic [4:0] wid, input logic ld, input logic [1:0] su,
        input logic [4:0] s0, input logic [4:0] s1, input logic rd,
        input logic e_st, input logic e_ffd, input logic e_fde,
        input logic [1:0] f0, input logic [1:0] f1, input logic [1:0] e_pend
    );
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        ext_stall     = es;
        issue_valid   = iv;
        issue_wr_en   = we;
        issue_wr_id   = wid;
        issue_is_load = ld;
        src_used      = su;
        src_id        = {s1, s0};
        redirect      = rd;
        tag++;
        e.tag  = tag;
        e.st   = e_st;
        e.ffd  = e_ffd;
        e.fde  = e_fde;
        e.fwd  = {f1, f0};
        e.pend = e_pend;
`ifdef HAZARD_PERF_EN
        e.sc   = exp_sc;
`else
        e.sc   = 16'h0000;
`endif
        q.push_back(e);
        if (rst) begin
            exp_sc = 16'h0000;
        end else if (e_fde) begin
            exp_sc = exp_sc + 16'h0001;
        end
    endtask

    initial begin
        reset = 1'b1; ext_stall = 1'b0; issue_valid = 1'b0; issue_wr_en = 1'b0;
        issue_wr_id = 5'd0; issue_is_load = 1'b0; src_used = 2'b00;
        src_id = 10'd0; redirect = 1'b0;
        repeat (2) @(posedge clk);
        //   rst  es   iv   we   wid    ld   su     s0     s1     rd     st   ffd  fde  f0     f1     pend
        cyc(1'b1,1'b0,1'b0,1'b0,5'd0, 1'b0,2'b00,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd0); // reset state
        // ALU producer forwarded from M then W, then read from regfile
        cyc(1'b0,1'b0,1'b1,1'b1,5'd8, 1'b0,2'b00,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd0);
        cyc(1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,2'b00,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd1);
        cyc(1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,2'b01,5'd8, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd2,2'd0,2'd1);
        cyc(1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,2'b01,5'd8, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd3,2'd0,2'd1);
        cyc(1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,2'b01,5'd8, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd0);
        // load at M: one stall cycle, then forward from W
        cyc(1'b0,1'b0,1'b1,1'b1,5'd9, 1'b1,2'b00,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd0);
        cyc(1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,2'b00,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd1);
        cyc(1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,2'b10,5'd0, 5'd9, 1'b0, 1'b1,1'b0,1'b1,2'd0,2'd0,2'd1);
        cyc(1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,2'b10,5'd0, 5'd9, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd3,2'd1);
        // ALU result still in E: one stall; stalled consumer (writes 6) enters after
        cyc(1'b0,1'b0,1'b1,1'b1,5'd5, 1'b0,2'b00,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd0);
        cyc(1'b0,1'b0,1'b1,1'b1,5'd6, 1'b0,2'b01,5'd5, 5'd0, 1'b0, 1'b1,1'b0,1'b1,2'd0,2'd0,2'd1);
        cyc(1'b0,1'b0,1'b1,1'b1,5'd6, 1'b0,2'b01,5'd5, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd2,2'd0,2'd1);
        // same id twice: younger entry wins
        cyc(1'b0,1'b0,1'b1,1'b1,5'd4, 1'b0,2'b00,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd2);
        cyc(1'b0,1'b0,1'b1,1'b1,5'd4, 1'b0,2'b00,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd2);
        cyc(1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,2'b00,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd3);
        cyc(1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,2'b01,5'd4, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd2,2'd0,2'd2);
        // write to id 0 is not tracked; read of id 0 never matches
        cyc(1'b0,1'b0,1'b1,1'b1,5'd0, 1'b0,2'b01,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd1);
        cyc(1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,2'b01,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd0);
        // redirect without hazard, then redirect held across a 2-cycle load-use stall
        cyc(1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,2'b00,5'd0, 5'd0, 1'b1, 1'b0,1'b1,1'b0,2'd0,2'd0,2'd0);
        cyc(1'b0,1'b0,1'b1,1'b1,5'd7, 1'b1,2'b00,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd0);
        cyc(1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,2'b01,5'd7, 5'd0, 1'b1, 1'b1,1'b0,1'b1,2'd0,2'd0,2'd1);
        cyc(1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,2'b01,5'd7, 5'd0, 1'b1, 1'b1,1'b0,1'b1,2'd0,2'd0,2'd1);
        cyc(1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,2'b01,5'd7, 5'd0, 1'b1, 1'b0,1'b1,1'b0,2'd3,2'd0,2'd1);
        // external freeze with two pending writes
        cyc(1'b0,1'b0,1'b1,1'b1,5'd10,1'b0,2'b00,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd0);
        cyc(1'b0,1'b0,1'b1,1'b1,5'd11,1'b0,2'b00,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd1);
        cyc(1'b0,1'b1,1'b1,1'b1,5'd12,1'b0,2'b00,5'd0, 5'd0, 1'b1, 1'b1,1'b0,1'b0,2'd0,2'd0,2'd2);
        cyc(1'b0,1'b1,1'b1,1'b0,5'd0, 1'b0,2'b01,5'd11,5'd0, 1'b0, 1'b1,1'b0,1'b0,2'd0,2'd0,2'd2);
        cyc(1'b0,1'b1,1'b1,1'b1,5'd12,1'b0,2'b00,5'd0, 5'd0, 1'b1, 1'b1,1'b0,1'b0,2'd0,2'd0,2'd2);
        cyc(1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,2'b00,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd2);
        cyc(1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,2'b11,5'd10,5'd11,1'b0, 1'b0,1'b0,1'b0,2'd3,2'd2,2'd2);
        // reset in the middle of a load-use stall
        cyc(1'b0,1'b0,1'b1,1'b1,5'd13,1'b1,2'b00,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd1);
        cyc(1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,2'b01,5'd13,5'd0, 1'b0, 1'b1,1'b0,1'b1,2'd0,2'd0,2'd1);
        cyc(1'b1,1'b0,1'b1,1'b0,5'd0, 1'b0,2'b01,5'd13,5'd0, 1'b0, 1'b1,1'b0,1'b1,2'd0,2'd0,2'd1);
        cyc(1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,2'b01,5'd13,5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd0);
        cyc(1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,2'b00,5'd0, 5'd0, 1'b0, 1'b0,1'b0,1'b0,2'd0,2'd0,2'd0);
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
